note_oscillator: RTL and testbench
==================================

// Module: note_oscillator
// PURPOSE
//   Upstream tone source for adsr: phase-accumulator oscillator producing one signed
//   16-bit sample per codec request (48 kHz). Drives adsr sample_in/in_ready.
//   Supplies a note gate and a fixed release tail so the envelope can finish
//   before the source falls silent.
// PARAMETERS
//   ACC_W          24    phase accumulator width; f_out = phase_step*48000/2^ACC_W
//   TAIL_SAMPLES   4800  samples kept running after note_off (matches adsr t_r)
//   AMP            32767 square-wave magnitude
// PORTS
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous, active-low reset
//   sample_req  in   1      1-cycle strobe from codec side, one per output sample
//   note_on     in   1      1-cycle strobe: start/retrigger note
//   note_off    in   1      1-cycle strobe: release note
//   phase_step  in   ACC_W  per-sample phase increment, latched on note_on
//   wave_sel    in   2      0 saw, 1 square, 2 triangle, 3 sine; latched on note_on
//   sample_out  out  16     signed sample; holds between updates
//   out_ready   out  1      1-cycle strobe, sample_out valid (to adsr in_ready)
//   gate        out  1      high from note_on until note_off
//   active      out  1      high in PLAY or TAIL
//   overrun     out  1      sticky: sample_req arrived while pipeline busy
// BEHAVIOUR
//   Reset (async, immediate, also mid-note): phase=0, step=0, wave=0, state=IDLE,
//     tail counter=0, sample_out=0, out_ready=0, gate=0, active=0, overrun=0.
//   FSM states IDLE, PLAY, TAIL:
//     IDLE: note_on -> PLAY. sample_req still served, sample_out=0.
//     PLAY: note_on -> retrigger (phase=0, relatch step/wave); note_off -> TAIL,
//       gate=0, tail counter=0.
//     TAIL: each served sample_req increments counter; after TAIL_SAMPLES-th
//       sample -> IDLE. note_on -> PLAY, counter cleared, phase=0.
//     note_on and note_off in same cycle: note_on wins, note_off ignored.
//     note_on coincident with sample_req: note applied first, sample uses phase 0.
//   Pipeline (LATENCY=2): req at cycle N -> cycle N+1 phase<=phase+step (mod
//     2^ACC_W; sample uses pre-increment phase) and waveform index registered;
//     cycle N+2 sample_out updated, out_ready=1 for exactly one cycle.
//   sample_req while an earlier req is in flight (<3 cycles apart): dropped,
//     overrun set (clears only on reset). First sample after note_on uses phase 0.
//   Waveforms, p = phase[ACC_W-1 -: 16] (top 16 bits):
//     saw:      p ^ 16'h8000 (phase 0 -> -32768)
//     square:   p[15] ? -AMP : +AMP
//     triangle: u = p[15] ? ~{p[14:0],1'b0} : {p[14:0],1'b0}; out = u ^ 16'h8000
//     sine:     quarter-wave ROM, addr = p[13:6] (bit-inverted when p[14]=1),
//               15-bit magnitude, negated when p[15]=1
//   phase_step=0: constant output (DC) legal. wave_sel/phase_step changes between
//     note_on strobes have no effect.
// STRUCTURE
//   Shared package (synth_pkg): wave-select codes, FSM state encodings,
//     SAMPLE_RATE=48000, SAMPLE_W=16.
//   Sub-module sine_quarter_rom: 256x15 registered ROM, 1-cycle read latency,
//     contents = round(32767*sin((i+0.5)*pi/512)).
// TESTING
//   1 Reset, 10 sample_req, no note -> 10 out_ready pulses, each 2 cycles after req,
//     sample_out=0, active=0.
//   2 note_on step=0x100000 wave=0, 16 reqs -> saw -32768,-28672,...,+28672 then wraps
//     to -32768; gate=1, active=1.
//   3 wave=1 step=0x200000: 4 samples +32767, 4 samples -32767, repeating;
//     wave=2 step=0x100000 -> -32768,-24576,...,+32767 peak, symmetric descent.
//   4 note_off with TAIL_SAMPLES=4 -> gate=0 next cycle, 4 more oscillating
//     samples, then active=0 and zeros; note_on during tail -> PLAY, phase 0.
//   5 sample_req two cycles apart -> second dropped, overrun=1, single out_ready.
//   6 note_on+note_off same cycle -> PLAY, gate=1; assert reset_n low mid-note ->
//     all outputs 0 immediately, no out_ready after release.

Source files
------------

// File: rtl/note_oscillator_pkg.sv
// Shared types and constants for the note oscillator and its sine table.
package note_oscillator_pkg;

  localparam int SAMPLE_RATE = 48000;
  localparam int SAMPLE_W    = 16;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_TAIL = 2'd2
  } osc_state_e;

  // Quarter-wave entry with half-step offset, evaluated at elaboration time.
  function automatic logic [14:0] sine_entry(input int idx);
    return 15'($rtoi(32767.0 * $sin(($itor(idx) + 0.5) * 3.141592653589793 / 512.0) + 0.5));
  endfunction

  // Phase increment for a tone of hz Hz with a 24-bit accumulator.
  function automatic logic [23:0] hz_to_step(input int hz);
    return 24'((longint'(hz) <<< 24) / SAMPLE_RATE);
  endfunction

endpackage

// File: rtl/note_oscillator_sine_rom.sv
// 256x15 quarter-wave sine table; data_o is valid one cycle after addr_i.
module note_oscillator_sine_rom
  import note_oscillator_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [7:0]  addr_i,
  output logic [14:0] data_o
);

  logic [14:0] rom_w [256];
  logic [14:0] data_q;

  for (genvar i = 0; i < 256; i++) begin : g_rom
    localparam logic [14:0] ENTRY = sine_entry(i);
    assign rom_w[i] = ENTRY;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q <= '0;
    end else begin
      data_q <= rom_w[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/note_oscillator.sv
// Phase-accumulator tone source with gate and release tail; each accepted sample_req
// yields sample_out/out_ready 2 cycles later, requests arriving while busy are dropped.
module note_oscillator
  import note_oscillator_pkg::*;
#(
  parameter int ACC_W        = 24,
  parameter int TAIL_SAMPLES = 4800,
  parameter int AMP          = 32767
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                sample_req_i,
  input  logic                note_on_i,
  input  logic                note_off_i,
  input  logic [ACC_W-1:0]    phase_step_i,
  input  logic [1:0]          wave_sel_i,
  output logic [SAMPLE_W-1:0] sample_out_o,
  output logic                out_ready_o,
  output logic                gate_o,
  output logic                active_o,
  output logic                overrun_o
);

  localparam int CNT_W = $clog2(TAIL_SAMPLES + 1);
  localparam logic [SAMPLE_W-1:0] POS_AMP   = SAMPLE_W'(AMP);
  localparam logic [SAMPLE_W-1:0] NEG_AMP   = SAMPLE_W'(-AMP);
  localparam logic [SAMPLE_W-1:0] SIGN_FLIP = {1'b1, {(SAMPLE_W-1){1'b0}}};

  osc_state_e          state_q, state_d, note_state;
  logic [ACC_W-1:0]    phase_q, phase_d, phase_n;
  logic [ACC_W-1:0]    step_q, step_d;
  wave_e               wave_q, wave_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gate_q, gate_d;
  logic                overrun_q, overrun_d;
  logic                busy, serve;
  logic [SAMPLE_W-1:0] p_n;
  logic [7:0]          rom_addr;
  logic [14:0]         rom_dat;

  logic                s1_vld_q, s1_silent_q;
  wave_e               s1_wave_q;
  logic [SAMPLE_W-1:0] s1_p_q;
  logic [SAMPLE_W-1:0] tri_u, wave_val, sample_q;
  logic                rdy_q;

  // A request is in flight for two cycles; anything arriving then is lost.
  assign busy  = s1_vld_q | rdy_q;
  assign serve = sample_req_i & ~busy;

  always_comb begin
    note_state = state_q;
    state_d    = state_q;
    phase_n    = phase_q;
    phase_d    = phase_q;
    step_d     = step_q;
    wave_d     = wave_q;
    cnt_d      = cnt_q;
    gate_d     = gate_q;
    overrun_d  = overrun_q | (sample_req_i & busy);

    // Note strobes act before a coincident request, so a fresh note samples phase 0.
    if (note_on_i) begin
      note_state = ST_PLAY;
      phase_n    = '0;
      step_d     = phase_step_i;
      wave_d     = wave_e'(wave_sel_i);
      cnt_d      = '0;
      gate_d     = 1'b1;
    end else if (note_off_i && state_q == ST_PLAY) begin
      note_state = ST_TAIL;
      cnt_d      = '0;
      gate_d     = 1'b0;
    end

    state_d = note_state;
    phase_d = phase_n;
    if (serve && note_state != ST_IDLE) begin
      phase_d = phase_n + step_d;
    end
    if (serve && note_state == ST_TAIL) begin
      if (cnt_d == CNT_W'(TAIL_SAMPLES - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  assign p_n      = phase_n[ACC_W-1 -: SAMPLE_W];
  assign rom_addr = p_n[14] ? ~p_n[13:6] : p_n[13:6];

  note_oscillator_sine_rom u_sine_rom (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .addr_i    (rom_addr),
    .data_o    (rom_dat)
  );

  assign tri_u = s1_p_q[15] ? ~{s1_p_q[14:0], 1'b0} : {s1_p_q[14:0], 1'b0};

  always_comb begin
    wave_val = '0;
    unique case (s1_wave_q)
      WAVE_SAW:    wave_val = s1_p_q ^ SIGN_FLIP;
      WAVE_SQUARE: wave_val = s1_p_q[15] ? NEG_AMP : POS_AMP;
      WAVE_TRI:    wave_val = tri_u ^ SIGN_FLIP;
      WAVE_SINE:   wave_val = s1_p_q[15] ? -{1'b0, rom_dat} : {1'b0, rom_dat};
    endcase
    if (s1_silent_q) begin
      wave_val = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      step_q      <= '0;
      wave_q      <= WAVE_SAW;
      cnt_q       <= '0;
      gate_q      <= 1'b0;
      overrun_q   <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_silent_q <= 1'b0;
      s1_wave_q   <= WAVE_SAW;
      s1_p_q      <= '0;
      sample_q    <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      wave_q    <= wave_d;
      cnt_q     <= cnt_d;
      gate_q    <= gate_d;
      overrun_q <= overrun_d;
      s1_vld_q  <= serve;
      if (serve) begin
        s1_p_q      <= p_n;
        s1_wave_q   <= wave_d;
        s1_silent_q <= (note_state == ST_IDLE);
      end
      rdy_q <= s1_vld_q;
      if (s1_vld_q) begin
        sample_q <= wave_val;
      end
    end
  end

  assign sample_out_o = sample_q;
  assign out_ready_o  = rdy_q;
  assign gate_o       = gate_q;
  assign active_o     = (state_q != ST_IDLE);
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_note_oscillator.sv
// Randomized and directed checks of note_oscillator against a sample-level reference model.
module tb_note_oscillator;

  localparam int TAILN = 4;

  typedef struct {
    int v;
    int c;
  } smp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_req, note_on, note_off;
  logic [23:0] phase_step;
  logic [1:0]  wave_sel;
  logic [15:0] sample_out;
  logic        out_ready, gate, active, overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  smp_t exp_q[$];
  smp_t got_q[$];

  // reference model state: 0 idle, 1 playing, 2 release tail
  int          m_state, m_cnt, m_wave, last_acc;
  int unsigned m_phase, m_step;
  bit          m_gate, m_ovr;

  note_oscillator #(.ACC_W(24), .TAIL_SAMPLES(TAILN), .AMP(32767)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .sample_req_i (sample_req),
    .note_on_i    (note_on),
    .note_off_i   (note_off),
    .phase_step_i (phase_step),
    .wave_sel_i   (wave_sel),
    .sample_out_o (sample_out),
    .out_ready_o  (out_ready),
    .gate_o       (gate),
    .active_o     (active),
    .overrun_o    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && out_ready) got_q.push_back(smp_t'{v: int'($signed(sample_out)), c: cyc});
  end

  function automatic int ref_wave(input int w, input int unsigned ph);
    int p, q, a, m;
    p = int'((ph >> 8) & 32'hFFFF);
    case (w)
      0: return p - 32768;
      1: return (p < 32768) ? 32767 : -32767;
      2: return (p < 32768) ? (-32768 + 2 * p) : (32767 - 2 * (p - 32768));
      default: begin
        q = p % 32768;
        a = (q < 16384) ? (q / 64) : (255 - (q - 16384) / 64);
        m = $rtoi(32767.0 * $sin(($itor(a) + 0.5) * 3.141592653589793 / 512.0) + 0.5);
        return (p < 32768) ? m : -m;
      end
    endcase
  endfunction

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_wave = 0; m_phase = 0; m_step = 0;
    m_gate = 0; m_ovr = 0; last_acc = -100;
    exp_q.delete();
  endfunction

  function automatic void model_step(input bit req, input bit on, input bit off,
                                     input logic [23:0] step, input logic [1:0] wave);
    if (on) begin
      m_state = 1; m_phase = 0; m_step = step; m_wave = wave; m_cnt = 0; m_gate = 1;
    end else if (off && m_state == 1) begin
      m_state = 2; m_cnt = 0; m_gate = 0;
    end
    if (req) begin
      if (cyc - last_acc < 3) begin
        m_ovr = 1;
      end else begin
        last_acc = cyc;
        exp_q.push_back(smp_t'{v: (m_state == 0) ? 0 : ref_wave(m_wave, m_phase), c: cyc + 2});
        if (m_state != 0) m_phase = (m_phase + m_step) % 32'h0100_0000;
        if (m_state == 2) begin
          m_cnt++;
          if (m_cnt == TAILN) begin m_state = 0; m_cnt = 0; end
        end
      end
    end
  endfunction

  task automatic drive(input bit req, input bit on, input bit off,
                       input logic [23:0] step, input logic [1:0] wave);
    sample_req = req; note_on = on; note_off = off; phase_step = step; wave_sel = wave;
    model_step(req, on, off, step, wave);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    sample_req = 0; note_on = 0; note_off = 0;
  endtask

  task automatic reqs(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 24'($urandom), 2'($urandom));
      drive(0, 0, 0, 24'($urandom), 2'($urandom));
      drive(0, 0, 0, 24'($urandom), 2'($urandom));
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({sample_out, out_ready, gate, active, overrun} !== 20'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {sample_out, out_ready, gate, active, overrun});
    end
    reset_n = 1;
    @(negedge clk);
    reqs(10);
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL idle_active got=%b want=0", active); end
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL idle_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].c !== exp_q[i].c) begin
        bad++; $display("FAIL idle_sample%0d got=%0d@%0d want=%0d@%0d", i, got_q[i].v, got_q[i].c, exp_q[i].v, exp_q[i].c);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_saw();
    drive(0, 1, 0, 24'h100000, 2'd0);
    reqs(17);
    total++;
    if ({gate, active} !== 2'b11) begin bad++; $display("FAIL saw_gate_active got=%b want=11", {gate, active}); end
    total++;
    if (got_q.size() != 17 || got_q[16].v !== -32768 || got_q[15].v !== 28672) begin
      bad++; $display("FAIL saw_wrap got=%0d samples want 17 ending 28672,-32768", got_q.size());
    end
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL saw_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].c !== exp_q[i].c) begin
        bad++; $display("FAIL saw_sample%0d got=%0d@%0d want=%0d@%0d", i, got_q[i].v, got_q[i].c, exp_q[i].v, exp_q[i].c);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_square_tri();
    drive(1, 1, 0, 24'h200000, 2'd1);
    drive(0, 0, 0, 24'h0, 2'd0);
    drive(0, 0, 0, 24'h0, 2'd0);
    reqs(11);
    total++;
    if (got_q.size() < 12 || got_q[0].v !== 32767 || got_q[4].v !== -32767 || got_q[8].v !== 32767) begin
      bad++; $display("FAIL square_shape got=%0d samples want 12 alternating by 4", got_q.size());
    end
    drive(0, 1, 0, 24'h100000, 2'd2);
    reqs(17);
    total++;
    if (got_q.size() < 21 || got_q[12].v !== -32768 || got_q[20].v !== 32767) begin
      bad++; $display("FAIL tri_shape got=%0d samples want -32768 start, 32767 peak", got_q.size());
    end
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL sqtri_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].c !== exp_q[i].c) begin
        bad++; $display("FAIL sqtri_sample%0d got=%0d@%0d want=%0d@%0d", i, got_q[i].v, got_q[i].c, exp_q[i].v, exp_q[i].c);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_tail();
    drive(0, 1, 0, 24'h100000, 2'd0);
    reqs(3);
    drive(0, 0, 1, 24'h0, 2'd0);
    total++;
    if ({gate, active} !== 2'b01) begin bad++; $display("FAIL tail_gate got=%b want=01", {gate, active}); end
    reqs(6);
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL tail_done got=%b want=0", active); end
    total++;
    if (got_q.size() != 9 || got_q[6].v !== -8192 || got_q[7].v !== 0 || got_q[8].v !== 0) begin
      bad++; $display("FAIL tail_shape got=%0d samples want 9 ending -8192,0,0", got_q.size());
    end
    drive(0, 1, 0, 24'h100000, 2'd3);
    reqs(2);
    drive(0, 0, 1, 24'h0, 2'd0);
    reqs(2);
    drive(0, 1, 0, 24'h080000, 2'd0);
    total++;
    if ({gate, active} !== 2'b11) begin bad++; $display("FAIL tail_retrig got=%b want=11", {gate, active}); end
    reqs(2);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL tail_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].c !== exp_q[i].c) begin
        bad++; $display("FAIL tail_sample%0d got=%0d@%0d want=%0d@%0d", i, got_q[i].v, got_q[i].c, exp_q[i].v, exp_q[i].c);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overrun();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_initial got=%b want=0", overrun); end
    drive(1, 0, 0, 24'h0, 2'd0);
    drive(0, 0, 0, 24'h0, 2'd0);
    drive(1, 0, 0, 24'h0, 2'd0);
    repeat (4) drive(0, 0, 0, 24'h0, 2'd0);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
    total++;
    if (got_q.size() !== 1 || exp_q.size() !== 1) begin
      bad++; $display("FAIL ovr_pulses got=%0d want=1", got_q.size());
    end else if (got_q[0].v !== exp_q[0].v || got_q[0].c !== exp_q[0].c) begin
      bad++; $display("FAIL ovr_sample got=%0d@%0d want=%0d@%0d", got_q[0].v, got_q[0].c, exp_q[0].v, exp_q[0].c);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_onoff_reset();
    drive(0, 1, 1, 24'h100000, 2'd0);
    total++;
    if ({gate, active} !== 2'b11) begin bad++; $display("FAIL onoff_gate got=%b want=11", {gate, active}); end
    reqs(2);
    total++;
    if (got_q.size() != 2 || got_q[1].v !== -28672 || int'($signed(sample_out)) !== -28672) begin
      bad++; $display("FAIL onoff_play got=%0d samples want 2 ending -28672", got_q.size());
    end
    drive(1, 0, 0, 24'h0, 2'd0);
    reset_n = 0;
    #1;
    total++;
    if ({sample_out, out_ready, gate, active, overrun} !== 20'd0) begin
      bad++; $display("FAIL midnote_reset got=%h want=0", {sample_out, out_ready, gate, active, overrun});
    end
    got_q.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1;
    repeat (5) drive(0, 0, 0, 24'h0, 2'd0);
    total++;
    if (got_q.size() !== 0) begin bad++; $display("FAIL reset_flush got=%0d pulses want=0", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit          rq, on, off;
    logic [23:0] st;
    for (int i = 0; i < 600; i++) begin
      rq  = ($urandom_range(0, 2) == 0);
      on  = ($urandom_range(0, 39) == 0);
      off = ($urandom_range(0, 24) == 0);
      st  = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom);
      drive(rq, on, off, st, 2'($urandom));
      total++;
      if ({gate, active, overrun} !== {m_gate, m_state != 0, m_ovr}) begin
        bad++; $display("FAIL rand_status cycle %0d got=%b want=%b", cyc, {gate, active, overrun}, {m_gate, m_state != 0, m_ovr});
      end
    end
    repeat (3) drive(0, 0, 0, 24'h0, 2'd0);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].c !== exp_q[i].c) begin
        bad++; $display("FAIL rand_sample%0d got=%0d@%0d want=%0d@%0d", i, got_q[i].v, got_q[i].c, exp_q[i].v, exp_q[i].c);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    reset_n = 0; sample_req = 0; note_on = 0; note_off = 0; phase_step = '0; wave_sel = '0;
    model_reset();
    test_reset();
    test_saw();
    test_square_tri();
    test_tail();
    test_overrun();
    test_onoff_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
